// File: rtl/alu_cmd_engine.sv
// Purpose : assembles opcode + two LSB-first operands from a byte stream, executes the ALU op, streams status + result back.
// Latency : m_axis_tvalid rises two edges after the last frame byte is accepted; response bytes then issue back to back.
// Backpressure: s_axis_tready is low from EXEC until the last response byte is accepted; TX holds its byte until m_axis_tready.
//
// Ports:
//   clk_i, rst_ni                  single clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tready     request bytes from the UART receiver
//   m_axis_tdata/tvalid/tready     response bytes to the UART transmitter
//   busy_o                         high whenever the engine is not in IDLE
//   timeout_o                      one-cycle pulse when a partial frame is discarded
// Optional feature macro: ALU_CMD_CHECKSUM_EN (frame checksum byte in, response checksum byte out).
module alu_cmd_engine #(
    parameter int OPERAND_BYTES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       busy_o,
    output logic       timeout_o
);

    localparam int W   = 8 * OPERAND_BYTES;
    localparam int CW  = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
    localparam int TXW = $clog2(OPERAND_BYTES + 2);
    localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] BYTE_LAST = CW'(OPERAND_BYTES - 1);
    // Counter value seen on the edge that completes TIMEOUT_CYCLES idle cycles.
    localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
`ifdef ALU_CMD_CHECKSUM_EN
    localparam logic [TXW-1:0] RESP_LAST = TXW'(OPERAND_BYTES + 1);
`else
    localparam logic [TXW-1:0] RESP_LAST = TXW'(OPERAND_BYTES);
`endif

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RX_A = 3'd1;
    localparam logic [2:0] ST_RX_B = 3'd2;
    localparam logic [2:0] ST_CHK  = 3'd3;
    localparam logic [2:0] ST_EXEC = 3'd4;
    localparam logic [2:0] ST_TX   = 3'd5;

    logic [2:0]     state;
    logic [7:0]     opcode_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [CW-1:0]  byte_cnt;
    logic [W-1:0]   result_q;
    logic           err_q;
    logic [TXW-1:0] tx_idx;
    logic [TW-1:0]  to_cnt;
    logic           timeout_q;
    logic           tvalid_q;
    logic [7:0]     tdata_q;
    logic           chk_bad;
`ifdef ALU_CMD_CHECKSUM_EN
    logic [7:0]     frame_xor_q;
    logic           chk_bad_q;
    logic [7:0]     resp_xor;
`endif

    logic           rx_phase;
    logic           accept;
    logic           to_fire;
    logic [W-1:0]   alu_res;
    logic           op_ok;
    logic [TXW-1:0] sel_idx;
    logic [7:0]     resp_byte;
    logic [TXW-1:0] tx_last;

    assign rx_phase      = (state == ST_RX_A) || (state == ST_RX_B) || (state == ST_CHK);
    assign s_axis_tready = rst_ni && (rx_phase || (state == ST_IDLE));
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign to_fire       = (TIMEOUT_CYCLES != 0) && rx_phase && !accept && (to_cnt == TO_LAST);

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign busy_o        = (state != ST_IDLE);
    assign timeout_o     = timeout_q;

`ifdef ALU_CMD_CHECKSUM_EN
    assign chk_bad = chk_bad_q;
`else
    assign chk_bad = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        op_ok   = 1'b1;
        case (opcode_q)
            8'h10:   alu_res = a_q + b_q;
            8'h11:   alu_res = a_q - b_q;
            8'h12:   alu_res = a_q & b_q;
            8'h13:   alu_res = a_q | b_q;
            8'h14:   alu_res = a_q ^ b_q;
            8'h15:   alu_res = a_q * b_q;
            default: op_ok   = 1'b0;
        endcase
    end

`ifdef ALU_CMD_CHECKSUM_EN
    // Status is 0x00 on a valid response, so only the result bytes contribute.
    always_comb begin
        resp_xor = 8'h00;
        for (int i = 0; i < OPERAND_BYTES; i++) begin
            resp_xor = resp_xor ^ result_q[8*i +: 8];
        end
    end
`endif

    // While a byte is on the bus the next one is prepared, so the mux looks one ahead.
    assign sel_idx = tvalid_q ? tx_idx + TXW'(1) : tx_idx;
    assign tx_last = err_q ? '0 : RESP_LAST;

    always_comb begin
        resp_byte = 8'h00;
        if (sel_idx == '0) begin
            resp_byte = err_q ? 8'hEE : 8'h00;
        end
        for (int i = 0; i < OPERAND_BYTES; i++) begin
            if (sel_idx == TXW'(i + 1)) begin
                resp_byte = result_q[8*i +: 8];
            end
        end
`ifdef ALU_CMD_CHECKSUM_EN
        if (sel_idx == TXW'(OPERAND_BYTES + 1)) begin
            resp_byte = resp_xor;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            opcode_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            byte_cnt  <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            tx_idx    <= '0;
            to_cnt    <= '0;
            timeout_q <= 1'b0;
            tvalid_q  <= 1'b0;
            tdata_q   <= 8'h00;
`ifdef ALU_CMD_CHECKSUM_EN
            frame_xor_q <= 8'h00;
            chk_bad_q   <= 1'b0;
`endif
        end else begin
            timeout_q <= 1'b0;
            if (rx_phase && !accept && !to_fire) begin
                to_cnt <= to_cnt + TW'(1);
            end else begin
                to_cnt <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        opcode_q <= s_axis_tdata;
                        byte_cnt <= '0;
                        state    <= ST_RX_A;
`ifdef ALU_CMD_CHECKSUM_EN
                        frame_xor_q <= s_axis_tdata;
                        chk_bad_q   <= 1'b0;
`endif
                    end
                end
                ST_RX_A, ST_RX_B: begin
                    if (to_fire) begin
                        state     <= ST_IDLE;
                        timeout_q <= 1'b1;
                    end else if (accept) begin
                        // LSB arrives first: shift in at the top, operand is aligned after N bytes.
                        if (state == ST_RX_A) begin
                            a_q <= (a_q >> 8) | (W'(s_axis_tdata) << (W - 8));
                        end else begin
                            b_q <= (b_q >> 8) | (W'(s_axis_tdata) << (W - 8));
                        end
`ifdef ALU_CMD_CHECKSUM_EN
                        frame_xor_q <= frame_xor_q ^ s_axis_tdata;
`endif
                        if (byte_cnt == BYTE_LAST) begin
                            byte_cnt <= '0;
                            if (state == ST_RX_A) begin
                                state <= ST_RX_B;
                            end else begin
`ifdef ALU_CMD_CHECKSUM_EN
                                state <= ST_CHK;
`else
                                state <= ST_EXEC;
`endif
                            end
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                        end
                    end
                end
`ifdef ALU_CMD_CHECKSUM_EN
                ST_CHK: begin
                    if (to_fire) begin
                        state     <= ST_IDLE;
                        timeout_q <= 1'b1;
                    end else if (accept) begin
                        chk_bad_q <= (s_axis_tdata != frame_xor_q);
                        state     <= ST_EXEC;
                    end
                end
`endif
                ST_EXEC: begin
                    result_q <= (op_ok && !chk_bad) ? alu_res : '0;
                    err_q    <= !op_ok || chk_bad;
                    tx_idx   <= '0;
                    state    <= ST_TX;
                end
                ST_TX: begin
                    if (!tvalid_q) begin
                        tvalid_q <= 1'b1;
                        tdata_q  <= resp_byte;
                    end else if (m_axis_tready) begin
                        if (tx_idx == tx_last) begin
                            tvalid_q <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            tx_idx  <= tx_idx + TXW'(1);
                            tdata_q <= resp_byte;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
